apb_slave_regbank: RTL and testbench

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_slave_regbank_if.sv | 25 ++
 rtl/apb_reg_file.sv | 61 ++++++
 rtl/apb_slave_regbank.sv | 133 +++++++++++++
 tb/tb_apb_slave_regbank.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave register bank.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned MAX_WAIT_STATES = 15;
    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned ID_REG_IDX      = 0;

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between a master and the register-bank slave.
interface apb_slave_regbank_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_file.sv
// Word register storage with byte-strobe writes and an indexed read mux.
// Optional macro APB_PSTRB_EN: honour byte strobes instead of full-word writes.
module apb_reg_file
    import apb_pkg::*;
#(
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        IDX_W    = 6,
    parameter int unsigned        NUM_REGS = 8,
    parameter logic [DATA_W-1:0]  ID_VALUE = DATA_W'(32'hA9B0_0001)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_we,
    input  logic [IDX_W-1:0]            i_idx,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W/8-1:0]         i_strb,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_REGS*DATA_W-1:0]  o_reg_q
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic [STRB_W-1:0]               w_byte_en;

`ifdef APB_PSTRB_EN
    assign w_byte_en = i_strb;
`else
    // Strobes are ignored: every byte lane is always enabled.
    assign w_byte_en = i_strb | {STRB_W{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == ID_REG_IDX) ? ID_VALUE : '0;
            end
        end else if (i_we) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if ((i != ID_REG_IDX) && (i_idx == IDX_W'(i))) begin
                    for (int unsigned k = 0; k < STRB_W; k++) begin
                        if (w_byte_en[k]) begin
                            r_regs[i][k*8 +: 8] <= i_wdata[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_rdata = r_regs[i];
            end
        end
    end

    assign o_reg_q = r_regs;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with programmable wait states in front of a word register bank.
// Optional macro APB_PSTRB_EN: enables per-byte write strobes in apb_reg_file.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        NUM_REGS    = 8,
    parameter int unsigned        WAIT_STATES = 1,
    parameter logic [DATA_W-1:0]  ID_VALUE    = DATA_W'(32'hA9B0_0001)
) (
    input  logic                        pclk,
    input  logic                        preset,
    apb_slave_regbank_if.slave          bus,
    output logic [NUM_REGS*DATA_W-1:0]  reg_q
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    apb_state_t              r_state;
    apb_state_t              w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic [WAIT_CNT_W-1:0]   w_cnt_nxt;

    logic [ADDR_W-1:0]       r_addr;
    logic                    r_write;
    logic [DATA_W-1:0]       r_wdata;
    logic [STRB_W-1:0]       r_strb;

    logic [IDX_W-1:0]        w_idx;
    logic                    w_legal;
    logic                    w_done;
    logic                    w_err;
    logic                    w_we;
    logic                    w_pready;
    logic                    w_pslverr;
    logic [DATA_W-1:0]       w_prdata;
    logic [DATA_W-1:0]       w_rd_data;

    // State and wait-counter register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transfer attributes are frozen during SETUP so outputs never see live paddr.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (r_state == ST_SETUP) begin
            r_addr  <= bus.paddr;
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_cnt_nxt   = '0;
            end
            ST_ACCESS: begin
                if (w_done) begin
                    w_state_nxt = (bus.psel && !bus.penable) ? ST_SETUP : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + WAIT_CNT_W'(1);
                    if (!bus.psel) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_idx   = r_addr[ADDR_W-1:2];
    assign w_legal = (32'(w_idx) < NUM_REGS) && (r_addr[1:0] == 2'b00);

    // Output and write-enable logic, all from registered state.
    always_comb begin
        w_done    = (r_state == ST_ACCESS) && (r_cnt == WAIT_CNT_W'(WAIT_STATES));
        w_err     = w_done && (!w_legal || (r_write && (32'(w_idx) == ID_REG_IDX)));
        w_we      = w_done && r_write && !w_err;
        w_pready  = w_done;
        w_pslverr = w_err;
        w_prdata  = '0;
        if (w_done && !r_write && !w_err) begin
            w_prdata = w_rd_data;
        end
    end

    assign bus.pready  = w_pready;
    assign bus.pslverr = w_pslverr;
    assign bus.prdata  = w_prdata;

    apb_reg_file #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_reg_file (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .i_strb  (r_strb),
        .o_rdata (w_rd_data),
        .o_reg_q (reg_q)
    );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed self-checking bench for apb_slave_regbank (default parameters).
module tb_apb_slave_regbank;

    logic         pclk = 1'b0;
    logic         preset;
    logic [255:0] reg_q;
    logic [255:0] exp_q;
    int           n_vec  = 0;
    int           n_miss = 0;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    apb_slave_regbank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_slave_regbank dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus),
        .reg_q  (reg_q)
    );

    always #5 pclk = ~pclk;

    // Master driver: called #1 after a rising edge; returns at the completion cycle
    // with the bus still in access phase. acc = ACCESS cycle of pready, -1 on timeout.
    task automatic apb_xfer(input logic [7:0] a, input logic wr, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd,
                            output logic err, output int acc);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a;
        bus.pwrite = wr; bus.pwdata = d; bus.pstrb = s;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        acc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge pclk); #1;
            if (bus.pready) begin
                acc = i;
                break;
            end
        end
        rd  = bus.prdata;
        err = bus.pslverr;
    endtask

    task automatic bus_idle();
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        repeat (3) @(posedge pclk);
        #1;
        exp_q = {224'b0, ID};
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL reset_reg_q: got %h want %h", reg_q, exp_q); end
        n_vec++; if (bus.pready !== 1'b0) begin n_miss++; $display("FAIL reset_pready: got %b want 0", bus.pready); end
        n_vec++; if (bus.pslverr !== 1'b0) begin n_miss++; $display("FAIL reset_pslverr: got %b want 0", bus.pslverr); end
        n_vec++; if (bus.prdata !== 32'h0) begin n_miss++; $display("FAIL reset_prdata: got %h want 0", bus.prdata); end
        preset = 1'b0;
    endtask

    task automatic test_read_id();
        logic [31:0] rd; logic err; int acc;
        apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (acc !== 2) begin n_miss++; $display("FAIL id_latency: got %0d want 2", acc); end
        n_vec++; if (rd !== ID) begin n_miss++; $display("FAIL id_prdata: got %h want %h", rd, ID); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL id_pslverr: got %b want 0", err); end
        bus_idle();
        n_vec++; if (bus.prdata !== 32'h0) begin n_miss++; $display("FAIL id_prdata_after: got %h want 0", bus.prdata); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int acc;
        apb_xfer(8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, err, acc);
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL wr04_pslverr: got %b want 0", err); end
        n_vec++; if (rd !== 32'h0) begin n_miss++; $display("FAIL wr04_prdata: got %h want 0", rd); end
        bus_idle();
        exp_q[63:32] = 32'hDEAD_BEEF;
        n_vec++; if (reg_q[63:32] !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL wr04_reg_q: got %h want DEADBEEF", reg_q[63:32]); end
        apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL rd04_prdata: got %h want DEADBEEF", rd); end
        n_vec++; if (acc !== 2) begin n_miss++; $display("FAIL rd04_latency: got %0d want 2", acc); end
        bus_idle();
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int acc; logic [31:0] want;
        apb_xfer(8'h08, 1'b1, 32'h1234_5678, 4'b0011, rd, err, acc);
        bus_idle();
`ifdef APB_PSTRB_EN
        want = 32'h0000_5678;
`else
        want = 32'h1234_5678;
`endif
        exp_q[95:64] = want;
        apb_xfer(8'h08, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (rd !== want) begin n_miss++; $display("FAIL strb08_prdata: got %h want %h", rd, want); end
        bus_idle();
`ifdef APB_PSTRB_EN
        apb_xfer(8'h08, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, err, acc);
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL strb_zero_pslverr: got %b want 0", err); end
        bus_idle();
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL strb_zero_reg_q: got %h want %h", reg_q, exp_q); end
`endif
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int acc;
        apb_xfer(8'h20, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (err !== 1'b1 || acc !== 2) begin n_miss++; $display("FAIL err20: got err=%b acc=%0d want err=1 acc=2", err, acc); end
        n_vec++; if (rd !== 32'h0) begin n_miss++; $display("FAIL err20_prdata: got %h want 0", rd); end
        bus_idle();
        apb_xfer(8'h06, 1'b1, 32'h7777_7777, 4'hF, rd, err, acc);
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL err06: got %b want 1", err); end
        bus_idle();
        apb_xfer(8'h00, 1'b1, 32'h5555_AAAA, 4'hF, rd, err, acc);
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL err00_wr: got %b want 1", err); end
        bus_idle();
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL err_reg_q: got %h want %h", reg_q, exp_q); end
        bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 8'h00; bus.pwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            n_vec++; if (bus.pready !== 1'b0) begin n_miss++; $display("FAIL proto_err_pready cyc%0d: got %b want 0", i, bus.pready); end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int acc;
        apb_xfer(8'h0C, 1'b1, 32'hA5A5_0F0F, 4'hF, rd, err, acc);
        n_vec++; if (acc !== 2 || err !== 1'b0) begin n_miss++; $display("FAIL b2b_wr: got acc=%0d err=%b want acc=2 err=0", acc, err); end
        apb_xfer(8'h0C, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (acc !== 2) begin n_miss++; $display("FAIL b2b_rd_latency: got %0d want 2", acc); end
        n_vec++; if (rd !== 32'hA5A5_0F0F) begin n_miss++; $display("FAIL b2b_rd_prdata: got %h want A5A50F0F", rd); end
        bus_idle();
        exp_q[127:96] = 32'hA5A5_0F0F;
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL b2b_reg_q: got %h want %h", reg_q, exp_q); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int acc;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 8'h10;
        bus.pwrite = 1'b1; bus.pwdata = 32'h0000_0055; bus.pstrb = 4'hF;
        @(posedge pclk); #1; bus.penable = 1'b1;
        @(posedge pclk); #1;
        n_vec++; if (bus.pready !== 1'b0) begin n_miss++; $display("FAIL abort_wait_pready: got %b want 0", bus.pready); end
        bus.psel = 1'b0; bus.penable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            n_vec++; if ({bus.pready, bus.pslverr, bus.prdata} !== 34'h0) begin n_miss++; $display("FAIL abort_outputs cyc%0d: got %b%b_%h want 0", i, bus.pready, bus.pslverr, bus.prdata); end
        end
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL abort_reg_q: got %h want %h", reg_q, exp_q); end
        apb_xfer(8'h10, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (acc !== 2 || rd !== 32'h0) begin n_miss++; $display("FAIL abort_readback: got acc=%0d rd=%h want acc=2 rd=0", acc, rd); end
        bus_idle();
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic err; int acc;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 8'h14;
        bus.pwrite = 1'b1; bus.pwdata = 32'hCAFE_F00D; bus.pstrb = 4'hF;
        @(posedge pclk); #1; bus.penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        exp_q = {224'b0, ID};
        n_vec++; if ({bus.pready, bus.pslverr, bus.prdata} !== 34'h0) begin n_miss++; $display("FAIL rstmid_outputs: got %b%b_%h want 0", bus.pready, bus.pslverr, bus.prdata); end
        n_vec++; if (reg_q !== exp_q) begin n_miss++; $display("FAIL rstmid_reg_q: got %h want %h", reg_q, exp_q); end
        preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk); #1;
        n_vec++; if (bus.pready !== 1'b0 || reg_q !== exp_q) begin n_miss++; $display("FAIL rstmid_after: got pready=%b reg_q=%h want 0 / %h", bus.pready, reg_q, exp_q); end
        apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, rd, err, acc);
        n_vec++; if (acc !== 2 || rd !== ID || err !== 1'b0) begin n_miss++; $display("FAIL rstmid_id: got acc=%0d rd=%h err=%b want 2 %h 0", acc, rd, err, ID); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_read();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
